// File: rtl/ones_window_accum.sv
// ones_window_accum: sums per-byte ones counts into windows of WINDOW bytes and hands each closed window downstream.
module ones_window_accum #(
  parameter int WINDOW = 16,
  parameter int THRESH = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] numones,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic [7:0] out_sum,
  output logic [4:0] out_count,
  output logic       out_over,
  output logic       out_partial,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d, out_sum_q, out_sum_d, sum_next;
  logic [4:0] cnt_q, cnt_d, out_count_q, out_count_d, cnt_next;
  logic       out_over_q, out_over_d, out_partial_q, out_partial_d, err_q, err_d;
  logic       accept, full, close;
  logic [3:0] clamped;
  assign in_ready    = state_q == ACCUM;
  assign out_valid   = state_q == HOLD;
  assign out_sum     = out_sum_q;
  assign out_count   = out_count_q;
  assign out_over    = out_over_q;
  assign out_partial = out_partial_q;
  assign err         = err_q;
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    out_sum_d     = out_sum_q;
    out_count_d   = out_count_q;
    out_over_d    = out_over_q;
    out_partial_d = out_partial_q;
    accept        = in_valid & in_ready;
    clamped       = numones > 4'd8 ? 4'd8 : numones;
    sum_next      = acc_q + {4'd0, clamped};
    cnt_next      = cnt_q + 5'd1;
    full          = accept & (cnt_next == 5'(WINDOW));
    close         = full | (flush & (state_q == ACCUM) & (accept | (cnt_q != 5'd0)));
    err_d         = err_q | (accept & (numones > 4'd8));
    // accumulator is cleared as the window closes; it is invisible while the result is held
    if (close) begin
      state_d       = HOLD;
      out_sum_d     = accept ? sum_next : acc_q;
      out_count_d   = accept ? cnt_next : cnt_q;
      out_partial_d = ~full;
      out_over_d    = out_sum_d >= 8'(THRESH);
      acc_d         = 8'd0;
      cnt_d         = 5'd0;
    end else if (accept) begin
      acc_d = sum_next;
      cnt_d = cnt_next;
    end else if (state_q == HOLD && out_ready) begin
      state_d = ACCUM;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ACCUM;
      acc_q         <= 8'd0;
      cnt_q         <= 5'd0;
      out_sum_q     <= 8'd0;
      out_count_q   <= 5'd0;
      out_over_q    <= 1'b0;
      out_partial_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      out_sum_q     <= out_sum_d;
      out_count_q   <= out_count_d;
      out_over_q    <= out_over_d;
      out_partial_q <= out_partial_d;
      err_q         <= err_d;
    end
  end
endmodule

// File: tb/tb_ones_window_accum.sv
// tb_ones_window_accum: directed checks of windowing, flush, backpressure, clamping and reset.
module tb_ones_window_accum;
  logic       clk = 0, rst = 1;
  logic [3:0] numones = 0, b_num = 0;
  logic       in_valid = 0, flush = 0, out_ready = 1, b_valid = 0, b_flush = 0;
  logic       in_ready, out_over, out_partial, out_valid, err;
  logic [7:0] out_sum;
  logic [4:0] out_count;
  logic       b_in_ready, b_over, b_partial, b_out_valid, b_err;
  logic [7:0] b_sum;
  logic [4:0] b_count;
  int         pass_cnt = 0, tot_cnt = 0;
  always #5 clk = ~clk;
  ones_window_accum #(.WINDOW(16), .THRESH(64)) u_a (
    .clk(clk), .rst(rst), .numones(numones), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out_sum(out_sum), .out_count(out_count), .out_over(out_over),
    .out_partial(out_partial), .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );
  ones_window_accum #(.WINDOW(31), .THRESH(248)) u_b (
    .clk(clk), .rst(rst), .numones(b_num), .in_valid(b_valid), .in_ready(b_in_ready),
    .flush(b_flush), .out_sum(b_sum), .out_count(b_count), .out_over(b_over),
    .out_partial(b_partial), .out_valid(b_out_valid), .out_ready(1'b1), .err(b_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic feed(input int n, input logic [3:0] v);
    in_valid = 1;
    numones  = v;
    for (int i = 0; i < n; i++) tick();
    in_valid = 0;
  endtask
  initial begin
    int lows, pulses, stable;
    logic [7:0] cap_sum;
    logic [4:0] cap_cnt;
    logic cap_over, cap_part;
    tick();
    rst = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_count", out_count, 0);
    chk("rst_err", err, 0);
    lows = 0; pulses = 0; cap_sum = 0; cap_cnt = 0; cap_over = 0; cap_part = 1;
    in_valid = 1; numones = 4;
    for (int i = 0; i < 17; i++) begin
      tick();
      if (!in_ready) lows++;
      if (out_valid) begin
        pulses++;
        cap_sum = out_sum; cap_cnt = out_count; cap_over = out_over; cap_part = out_partial;
      end
    end
    in_valid = 0;
    chk("full_pulses", pulses, 1);
    chk("full_ready_low", lows, 1);
    chk("full_sum", cap_sum, 64);
    chk("full_count", cap_cnt, 16);
    chk("full_over", cap_over, 1);
    chk("full_partial", cap_part, 0);
    feed(5, 3);
    flush = 1;
    tick();
    flush = 0;
    chk("fl_valid", out_valid, 1);
    chk("fl_sum", out_sum, 15);
    chk("fl_count", out_count, 5);
    chk("fl_partial", out_partial, 1);
    chk("fl_over", out_over, 0);
    tick();
    chk("fl_drop", out_valid, 0);
    flush = 1;
    tick();
    chk("fl_empty1", out_valid, 0);
    tick();
    flush = 0;
    chk("fl_empty2", out_valid, 0);
    out_ready = 0;
    feed(16, 2);
    chk("bp_valid", out_valid, 1);
    stable = 0;
    in_valid = 1; numones = 8;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid && !in_ready && out_sum == 8'd32 && out_count == 5'd16 && !out_partial) stable++;
    end
    in_valid = 0;
    chk("bp_stable", stable, 10);
    out_ready = 1;
    tick();
    chk("bp_drop", out_valid, 0);
    chk("bp_hold_sum", out_sum, 32);
    in_valid = 1; numones = 1; flush = 1;
    tick();
    in_valid = 0; flush = 0;
    chk("bp_next_sum", out_sum, 1);
    chk("bp_next_count", out_count, 1);
    chk("bp_next_partial", out_partial, 1);
    tick();
    feed(4, 1);
    feed(1, 12);
    chk("clamp_err_edge", err, 1);
    feed(11, 1);
    chk("clamp_valid", out_valid, 1);
    chk("clamp_sum", out_sum, 23);
    chk("clamp_over", out_over, 0);
    tick();
    in_valid = 1; numones = 8; flush = 1;
    tick();
    in_valid = 0; flush = 0;
    chk("clamp_next_sum", out_sum, 8);
    chk("err_sticky", err, 1);
    tick();
    feed(7, 5);
    rst = 1;
    tick();
    rst = 0;
    chk("rstmid_valid", out_valid, 0);
    chk("rstmid_err", err, 0);
    chk("rstmid_sum", out_sum, 0);
    chk("rstmid_ready", in_ready, 1);
    out_ready = 0;
    feed(16, 5);
    chk("rsthold_pre_sum", out_sum, 80);
    chk("rsthold_pre_over", out_over, 1);
    rst = 1; out_ready = 1; in_valid = 1; flush = 1;
    tick();
    rst = 0; in_valid = 0; flush = 0;
    chk("rsthold_valid", out_valid, 0);
    chk("rsthold_sum", out_sum, 0);
    chk("rsthold_count", out_count, 0);
    chk("rsthold_over", out_over, 0);
    feed(3, 2);
    flush = 1;
    tick();
    flush = 0;
    chk("rst_next_sum", out_sum, 6);
    chk("rst_next_count", out_count, 3);
    tick();
    b_valid = 1; b_num = 8;
    for (int i = 0; i < 30; i++) tick();
    chk("w31_pre_valid", b_out_valid, 0);
    b_flush = 1;
    tick();
    b_valid = 0; b_flush = 0;
    chk("w31_valid", b_out_valid, 1);
    chk("w31_sum", b_sum, 248);
    chk("w31_count", b_count, 31);
    chk("w31_partial", b_partial, 0);
    chk("w31_over", b_over, 1);
    chk("w31_err", b_err, 0);
    tick();
    chk("w31_drop", b_out_valid, 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
